// File: rtl/pipe_pkg.sv
// Shared decode constants, FSM state type and operand-use helpers for the 3-stage pipeline.
package pipe_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] OP_LUI   = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_R     = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_S     = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_B     = 7'b1100011;

    localparam logic [1:0] WB_SEL_LOAD = 2'b01;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    // Per-cycle stage controls produced by the sequencer
    typedef struct packed {
        logic forA;
        logic forB;
        logic stallIf;
        logic stallDe;
        logic stallMw;
        logic flushDe;
        logic flushMw;
        logic memErr;
    } hz_ctrl_t;

    // rs1 is a real source for everything except the U-type and JAL formats
    function automatic logic uses_rs1(input logic [XLEN-1:0] ir);
        logic [OPC_W-1:0] op;
        op = ir[OPC_W-1:0];
        return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
    endfunction

    // rs2 is only read by register-register ALU ops, stores and branches
    function automatic logic uses_rs2(input logic [XLEN-1:0] ir);
        logic [OPC_W-1:0] op;
        op = ir[OPC_W-1:0];
        return (op == OP_R) || (op == OP_S) || (op == OP_B);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW detection between the MW write-back and the DE/EX source operands.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [XLEN-1:0] oldIR,
    input  logic [XLEN-1:0] newIR,
    input  logic            reg_wrMW,
    input  logic [1:0]      wb_selMW,
    output logic            hitA_c,
    output logic            hitB_c,
    output logic            loadUse_c
);

    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             mwWr;
    logic             unusedIrBits;

    // Fields outside the register specifiers and opcode play no part here
    assign unusedIrBits = ^{oldIR[31:12], oldIR[6:0], newIR[31:25], newIR[14:7]};

    // Decode register fields and match MW destination against DE sources
    always_comb begin
        rd        = oldIR[11:7];
        rs1       = newIR[19:15];
        rs2       = newIR[24:20];
        mwWr      = reg_wrMW && (rd != '0);
        hitA_c    = mwWr && uses_rs1(newIR) && (rs1 == rd);
        hitB_c    = mwWr && uses_rs2(newIR) && (rs2 == rd);
        loadUse_c = (hitA_c || hitB_c) && (wb_selMW == WB_SEL_LOAD);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Prioritised pipeline sequencer: forwarding, load-use bubble, branch flush,
// multi-cycle data-memory wait with watchdog. Optional perf counters are
// enabled with the HAZARD_PERF_CNT_EN macro.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  oldIR,
    input  logic [XLEN-1:0]  newIR,
    input  logic             reg_wrMW,
    input  logic [1:0]       wb_selMW,
    input  logic             br_taken,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             forA,
    output logic             forB,
    output logic             stall_IF,
    output logic             stall_DE,
    output logic             stall_MW,
    output logic             flush_DE,
    output logic             flush_MW,
    output logic             mem_err,
    output logic             busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_stall,
    output logic [CNT_W-1:0] perf_flush,
    output logic [CNT_W-1:0] perf_memwait
`endif
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 2 : $clog2(MEM_TIMEOUT + 1);

    hz_state_t         state;
    hz_state_t         nextState;
    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] nextCnt;
    hz_ctrl_t          ctrl;
    logic              runEval;
    logic              hitA;
    logic              hitB;
    logic              loadUse;

    hazard_detect u_detect (
        .oldIR     (oldIR),
        .newIR     (newIR),
        .reg_wrMW  (reg_wrMW),
        .wb_selMW  (wb_selMW),
        .hitA_c    (hitA),
        .hitB_c    (hitB),
        .loadUse_c (loadUse)
    );

    // State and watchdog counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= nextCnt;
        end
    end

    // Next state, counter update and stage controls
    always_comb begin
        ctrl      = '0;
        nextState = state;
        nextCnt   = waitCnt;
        runEval   = 1'b0;
        case (state)
            RUN: begin
                if (dmem_req && !dmem_ack) begin
                    ctrl.stallIf = 1'b1;
                    ctrl.stallDe = 1'b1;
                    ctrl.stallMw = 1'b1;
                    ctrl.forA    = hitA && !loadUse;
                    ctrl.forB    = hitB && !loadUse;
                    nextState    = MEM_WAIT;
                    nextCnt      = WAIT_W'(1);
                end else begin
                    runEval = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    runEval   = 1'b1;
                    nextState = RUN;
                    nextCnt   = '0;
                end else if ((MEM_TIMEOUT != 0) && (waitCnt >= WAIT_W'(MEM_TIMEOUT))) begin
                    ctrl.memErr  = 1'b1;
                    ctrl.flushMw = 1'b1;
                    nextState    = RUN;
                    nextCnt      = '0;
                end else begin
                    ctrl.stallIf = 1'b1;
                    ctrl.stallDe = 1'b1;
                    ctrl.stallMw = 1'b1;
                    nextCnt      = waitCnt + WAIT_W'(1);
                end
            end
            default: begin
                nextState = RUN;
                nextCnt   = '0;
            end
        endcase

        // Normal pipeline rules: load-use bubble beats a branch resolved from a stale operand
        if (runEval) begin
            ctrl.forA = hitA && !loadUse;
            ctrl.forB = hitB && !loadUse;
            if (loadUse) begin
                ctrl.stallIf = 1'b1;
                ctrl.stallDe = 1'b1;
                ctrl.flushMw = 1'b1;
            end else if (br_taken) begin
                ctrl.flushDe = 1'b1;
            end
        end
    end

    // Outputs forced low while reset is held, without waiting for a clock edge
    assign forA     = rst_n & ctrl.forA;
    assign forB     = rst_n & ctrl.forB;
    assign stall_IF = rst_n & ctrl.stallIf;
    assign stall_DE = rst_n & ctrl.stallDe;
    assign stall_MW = rst_n & ctrl.stallMw;
    assign flush_DE = rst_n & ctrl.flushDe;
    assign flush_MW = rst_n & ctrl.flushMw;
    assign mem_err  = rst_n & ctrl.memErr;
    assign busy     = rst_n & (state == MEM_WAIT);

`ifdef HAZARD_PERF_CNT_EN
    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall   <= '0;
            perf_flush   <= '0;
            perf_memwait <= '0;
        end else begin
            if (stall_IF && (perf_stall != '1))
                perf_stall <= perf_stall + CNT_W'(1);
            if (flush_DE && (perf_flush != '1))
                perf_flush <= perf_flush + CNT_W'(1);
            if ((state == MEM_WAIT) && (perf_memwait != '1))
                perf_memwait <= perf_memwait + CNT_W'(1);
        end
    end
`else
    logic [CNT_W-1:0] unusedPerfWidth;
    assign unusedPerfWidth = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected control vectors are queued as each
// step is driven and popped when the outputs are sampled.
module tb_hazard_ctrl;

    localparam int unsigned CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] oldIR, newIR;
    logic        reg_wrMW;
    logic [1:0]  wb_selMW;
    logic        br_taken, dmem_req, dmem_ack;
    logic        forA, forB, stall_IF, stall_DE, stall_MW;
    logic        flush_DE, flush_MW, mem_err, busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall, perf_flush, perf_memwait;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [8:0] vec;
    } exp_t;
    exp_t expQ[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .oldIR    (oldIR),
        .newIR    (newIR),
        .reg_wrMW (reg_wrMW),
        .wb_selMW (wb_selMW),
        .br_taken (br_taken),
        .dmem_req (dmem_req),
        .dmem_ack (dmem_ack),
        .forA     (forA),
        .forB     (forB),
        .stall_IF (stall_IF),
        .stall_DE (stall_DE),
        .stall_MW (stall_MW),
        .flush_DE (flush_DE),
        .flush_MW (flush_MW),
        .mem_err  (mem_err),
        .busy     (busy)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall   (perf_stall),
        .perf_flush   (perf_flush),
        .perf_memwait (perf_memwait)
`endif
    );

    // Expected vector layout: {forA,forB,stall_IF,stall_DE,stall_MW,flush_DE,flush_MW,mem_err,busy}
    localparam logic [8:0] NONE  = 9'b000000000;
    localparam logic [8:0] FWD   = 9'b110000000;
    localparam logic [8:0] FWDB_ONLY = 9'b010000000;
    localparam logic [8:0] LU    = 9'b001100100;
    localparam logic [8:0] BR    = 9'b000001000;
    localparam logic [8:0] ST3   = 9'b001110000;
    localparam logic [8:0] ST3B  = 9'b001110001;
    localparam logic [8:0] ACKB  = 9'b000000001;
    localparam logic [8:0] LUB   = 9'b001100101;
    localparam logic [8:0] FWDB  = 9'b110000001;
    localparam logic [8:0] ERR   = 9'b000000111;

    function automatic logic [31:0] mkR(input logic [4:0] rd, rs1, rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] mkI(input logic [6:0] op, input logic [4:0] rd, rs1,
                                        input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, op};
    endfunction

    // Drive one cycle of inputs, queue its expectation, sample 1 time unit later
    task automatic step(input string tag, input logic rst, input logic [31:0] o, n,
                        input logic rw, input logic [1:0] ws, input logic br, req, ack,
                        input logic [8:0] expVec);
        exp_t e;
        logic [8:0] got;
        @(negedge clk);
        rst_n = rst; oldIR = o; newIR = n; reg_wrMW = rw; wb_selMW = ws;
        br_taken = br; dmem_req = req; dmem_ack = ack;
        expQ.push_back('{tag, expVec});
        #1;
        e   = expQ.pop_front();
        got = {forA, forB, stall_IF, stall_DE, stall_MW, flush_DE, flush_MW, mem_err, busy};
        checks++;
        assert (got === e.vec) else begin
            errors++;
            $error("FAIL %s got %b exp %b", e.tag, got, e.vec);
        end
    endtask

    initial begin
        logic [31:0] add5, add0, sub655, lw7, addiDep, addiInd, luiFake, addiRs2f, beq7, sw5;
        add5     = mkR(5'd5, 5'd1, 5'd2);
        add0     = mkR(5'd0, 5'd1, 5'd2);
        sub655   = mkR(5'd6, 5'd5, 5'd5);
        lw7      = mkI(7'b0000011, 5'd7, 5'd10, 12'd0);
        addiDep  = mkI(7'b0010011, 5'd8, 5'd7, 12'd4);
        addiInd  = mkI(7'b0010011, 5'd8, 5'd9, 12'd4);
        luiFake  = {7'b0, 5'd5, 5'd5, 3'b000, 5'd6, 7'b0110111};
        addiRs2f = mkI(7'b0010011, 5'd6, 5'd1, 12'd5);
        beq7     = {7'b0, 5'd0, 5'd7, 3'b000, 5'd0, 7'b1100011};
        sw5      = {7'b0, 5'd5, 5'd1, 3'b010, 5'd0, 7'b0100011};

        rst_n = 1'b0; oldIR = '0; newIR = '0; reg_wrMW = 1'b0; wb_selMW = 2'b00;
        br_taken = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;

        // Reset with hazardous inputs present
        step("reset",        1'b0, add5, sub655, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, NONE);
        // Forwarding
        step("fwd_ab",       1'b1, add5, sub655, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, FWD);
        step("fwd_rd_x0",    1'b1, add0, sub655, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, NONE);
        step("fwd_no_wr",    1'b1, add5, sub655, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, NONE);
        step("fwd_lui",      1'b1, add5, luiFake, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, NONE);
        step("fwd_itype_rs2",1'b1, add5, addiRs2f, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, NONE);
        step("fwd_store_b",  1'b1, add5, sw5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, FWDB_ONLY);
        // Load-use
        step("load_use",     1'b1, lw7, addiDep, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, LU);
        step("lu_bubble",    1'b1, lw7, addiDep, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, NONE);
        step("load_indep",   1'b1, lw7, addiInd, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, NONE);
        // Branch vs load-use
        step("br_vs_lu",     1'b1, lw7, beq7, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, LU);
        step("br_flush",     1'b1, lw7, beq7, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, BR);
        step("br_done",      1'b1, lw7, beq7, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, NONE);
        // Memory wait: ack after 3 busy cycles
        step("mw_enter",     1'b1, lw7, addiInd, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, ST3);
        step("mw_wait1",     1'b1, lw7, addiInd, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, ST3B);
        step("mw_wait2",     1'b1, lw7, addiInd, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, ST3B);
        step("mw_wait3",     1'b1, lw7, addiInd, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, ST3B);
        step("mw_ack",       1'b1, lw7, addiInd, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, ACKB);
        step("mw_run",       1'b1, lw7, addiInd, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, NONE);
        // Ack cycle applies load-use
        step("mw2_enter",    1'b1, lw7, addiDep, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, ST3);
        step("mw2_ack_lu",   1'b1, lw7, addiDep, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, LUB);
        step("mw2_run",      1'b1, lw7, addiDep, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, NONE);
        // Forwarding masked during wait, restored on ack
        step("mw3_enter",    1'b1, lw7, addiInd, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, ST3);
        step("mw3_nofwd",    1'b1, add5, sub655, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, ST3B);
        step("mw3_ack_fwd",  1'b1, add5, sub655, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, FWDB);
        step("mw3_run",      1'b1, add5, sub655, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, NONE);
        // Watchdog: timeout 4, ack never comes
        step("wd_enter",     1'b1, lw7, addiInd, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, ST3);
        step("wd_wait1",     1'b1, lw7, addiInd, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, ST3B);
        step("wd_wait2",     1'b1, lw7, addiInd, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, ST3B);
        step("wd_wait3",     1'b1, lw7, addiInd, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, ST3B);
        step("wd_expire",    1'b1, lw7, addiInd, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, ERR);
        step("wd_stray_ack", 1'b1, lw7, addiInd, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, NONE);
        step("wd_idle",      1'b1, lw7, addiInd, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, NONE);
        // Reset asserted mid-wait
        step("rst_enter",    1'b1, lw7, addiInd, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, ST3);
        step("rst_wait",     1'b1, lw7, addiInd, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, ST3B);
        step("rst_async",    1'b0, add5, sub655, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, NONE);
        step("rst_held",     1'b0, lw7, addiDep, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, NONE);
        step("rst_release",  1'b1, lw7, addiInd, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, NONE);
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        assert ({perf_stall, perf_flush, perf_memwait} === '0) else begin
            errors++;
            $error("FAIL perf_after_reset got %0d/%0d/%0d exp 0/0/0",
                   perf_stall, perf_flush, perf_memwait);
        end
`endif
        step("post_rst_fwd", 1'b1, add5, sub655, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, FWD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
